ibex_rf_wb_queue: RTL
=====================

Name: ibex_rf_wb_queue

Overview:
- Writeback-side initiator for the SRAM-backed register file.
- Accepts register writebacks from the WB stage and buffers them in a small FIFO.
- Issues buffered writes to the register file write port one at a time, and honours the register file's stall pulse before issuing the next write.
- Forwards pending (not yet written) data to ID-stage read addresses, so reads never see stale SRAM contents.

Parameters:
- DataWidth, 32, register data width.
- Depth, 4, FIFO entries; power of 2, >= 2.
- RV32E, 0, 1 = only x0..x15 are legal; writes with waddr[4]=1 are dropped.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- wb_valid_i  in  1  writeback request valid.
- wb_ready_o  out  1  queue can accept; = !full_o.
- wb_waddr_i  in  5  destination register.
- wb_wdata_i  in  DataWidth  writeback data.
- rf_we_o  out  1  register file write enable (registered).
- rf_waddr_o  out  5  register file write address (registered).
- rf_wdata_o  out  DataWidth  register file write data (registered).
- rf_stall_i  in  1  stall pulse from the register file.
- raddr_a_i  in  5  ID read address, port A.
- raddr_b_i  in  5  ID read address, port B.
- fwd_hit_a_o  out  1  pending data exists for raddr_a_i.
- fwd_data_a_o  out  DataWidth  forwarded data, port A.
- fwd_hit_b_o  out  1  pending data exists for raddr_b_i.
- fwd_data_b_o  out  DataWidth  forwarded data, port B.
- count_o  out  $clog2(Depth)+1  occupied FIFO entries.
- empty_o  out  1  count_o == 0.
- full_o  out  1  count_o == Depth.
- drop_o  out  1  one-cycle pulse when an accepted request is discarded.

Behaviour:
- Reset (async, rst_i=1):
  - FIFO pointers and count cleared; FSM = IDLE.
  - rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, drop_o=0, fwd_hit_*=0, fwd_data_*=0.
  - empty_o=1, full_o=0, wb_ready_o=1.
  - Reset mid-drain discards every pending write; no partial write is issued after reset releases.
- Handshake:
  - A request is accepted when wb_valid_i && wb_ready_o at a rising edge.
  - If waddr==0, or RV32E && waddr[4], the request is accepted but not enqueued; drop_o=1 the following cycle.
  - Otherwise the request is written at the tail; count increments.
- Drain FSM, states IDLE, ISSUE, HOLD:
  - IDLE: if count>0, go to ISSUE. On this edge, load rf_* from the head and pop the head.
  - ISSUE: rf_we_o=1 for exactly one cycle; next state HOLD.
  - HOLD: rf_we_o=0. If rf_stall_i=1, stay in HOLD. If rf_stall_i=0 and count>0, go to ISSUE with the next pop. If rf_stall_i=0 and count==0, go to IDLE.
  - rf_we_o is 0 in IDLE and HOLD; rf_waddr_o and rf_wdata_o hold their last value.
- Latency and throughput:
  - Request accepted in cycle N into an empty, idle queue: rf_we_o=1 in cycle N+2.
  - Sustained throughput is 1 write per 2 cycles when rf_stall_i stays low.
- Simultaneous events:
  - Push and pop in the same cycle: count is unchanged.
  - When full, push is blocked (wb_ready_o=0) even if a pop occurs that cycle; no full-bypass.
  - Pointers wrap modulo Depth.
- Forwarding (combinational):
  - Candidates are the valid FIFO entries plus the rf_* output register while in ISSUE.
  - The youngest matching candidate wins; the in-flight ISSUE entry is the oldest.
  - raddr==0 never hits.
  - On a miss, fwd_hit=0 and fwd_data=0.
  - A request being accepted in the current cycle is not yet visible to forwarding.
- Ordering: writes reach the register file strictly in acceptance order.

Optional Feature:
- Macro: IBEX_RF_WB_COALESCE_EN.
- Defined:
  - An accepted write whose address matches a valid FIFO entry overwrites that entry's data in place.
  - count is unchanged and no new slot is used; at most one pending entry per address.
  - Coalescing is allowed while full, so wb_ready_o = !full_o || address match.
  - An entry popped in the same cycle is not a coalesce target; the request is enqueued normally.
- Undefined: every legal request takes a new slot; duplicate addresses are allowed and resolved by youngest-wins forwarding.

Test Plan:
- Reset, then release -> rf_we_o=0, wb_ready_o=1, empty_o=1, count_o=0, fwd_hit_a_o=0.
- Push x5=0xDEADBEEF in cycle 0, rf_stall_i=0 -> rf_we_o=1 in cycle 2 with rf_waddr_o=5, rf_wdata_o=0xDEADBEEF; raddr_a_i=5 gives fwd_hit_a_o=1, fwd_data_a_o=0xDEADBEEF in cycles 1-2; rf_we_o=0 in cycle 3.
- Push x7=1, then x7=2 (coalesce off) with rf_stall_i held 1 after the first issue -> raddr_b_i=7 gives fwd_data_b_o=2; after rf_stall_i drops, writes issue as 1 then 2.
- Hold rf_stall_i=1 and push 6 distinct registers -> the first issues, the next 4 fill the FIFO, full_o=1, wb_ready_o=0 on the 6th, count_o=4; releasing the stall drains them in order, 2 cycles apart.
- Push x0=0x1234, and x20 with RV32E=1 -> drop_o pulses once per request, count_o stays 0, no rf_we_o.
- Assert rst_i while count_o=3 and in HOLD -> all outputs reset immediately; after release, no rf_we_o without new pushes.
- With IBEX_RF_WB_COALESCE_EN: queue full with x3 pending, push x3=0xAA -> accepted, count_o stays Depth, fwd_data_a_o=0xAA for raddr_a_i=3.

Source files
------------

// File: rtl/ibex_rf_wb_queue.sv
// ibex_rf_wb_queue
// ----------------
// Writeback-side initiator for the SRAM-backed register file. Writebacks from
// the WB stage are buffered in a small FIFO. A three-state drain FSM
// (IDLE/ISSUE/HOLD) writes them to the register file one at a time. While the
// register file stalls, the next write is held back. Data that is pending and
// not yet written is forwarded to the two ID-stage read ports, so ID never
// reads a stale SRAM value.
//
// Optional feature: define IBEX_RF_WB_COALESCE_EN to merge a write into a
// pending FIFO entry for the same register. This also allows such a write to
// be accepted while the queue is full.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   wb_valid_i/wb_ready_o  writeback handshake
//   wb_waddr_i/wb_wdata_i  writeback destination register and data
//   rf_we_o/rf_waddr_o/rf_wdata_o  registered register-file write port
//   rf_stall_i             register-file stall pulse
//   raddr_a_i/raddr_b_i    ID read addresses
//   fwd_hit_*_o/fwd_data_*_o  forwarding result per read port
//   count_o/empty_o/full_o FIFO occupancy
//   drop_o                 one-cycle pulse when an accepted write is discarded
module ibex_rf_wb_queue #(
    parameter int DataWidth = 32,
    parameter int Depth     = 4,
    parameter bit RV32E     = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wb_valid_i,
    output logic                   wb_ready_o,
    input  logic [4:0]             wb_waddr_i,
    input  logic [DataWidth-1:0]   wb_wdata_i,
    output logic                   rf_we_o,
    output logic [4:0]             rf_waddr_o,
    output logic [DataWidth-1:0]   rf_wdata_o,
    input  logic                   rf_stall_i,
    input  logic [4:0]             raddr_a_i,
    input  logic [4:0]             raddr_b_i,
    output logic                   fwd_hit_a_o,
    output logic [DataWidth-1:0]   fwd_data_a_o,
    output logic                   fwd_hit_b_o,
    output logic [DataWidth-1:0]   fwd_data_b_o,
    output logic [$clog2(Depth):0] count_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic                   drop_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_e;

    typedef struct packed {
        logic                 hit;
        logic [DataWidth-1:0] data;
    } fwd_t;

    state_e               state_q, state_d;
    logic [PtrW-1:0]      rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]      count_q, count_d;
    logic [4:0]           addr_mem [Depth];
    logic [DataWidth-1:0] data_mem [Depth];

    logic                 rf_we_q;
    logic [4:0]           rf_waddr_q;
    logic [DataWidth-1:0] rf_wdata_q;
    logic                 drop_q;

    logic                 full, pop, push, accept, illegal;
    logic                 coal_hit;
    logic [PtrW-1:0]      coal_idx;
    fwd_t                 fwd_a, fwd_b;

    assign full    = (count_q == CntW'(Depth));
    assign illegal = (wb_waddr_i == 5'd0) || (RV32E && wb_waddr_i[4]);
    assign accept  = wb_valid_i && wb_ready_o;
    assign push    = accept && !illegal && !coal_hit;

    // Drain FSM: a pop always coincides with entering ISSUE.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = ISSUE;
                    pop     = 1'b1;
                end
            end
            ISSUE: state_d = HOLD;
            HOLD: begin
                if (!rf_stall_i) begin
                    if (count_q != '0) begin
                        state_d = ISSUE;
                        pop     = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef IBEX_RF_WB_COALESCE_EN
    // The head is excluded when it is popped on this edge. Merging into it
    // would lose the new data, because it is already on its way to rf_*.
    always_comb begin
        logic [PtrW-1:0] idx;
        coal_hit = 1'b0;
        coal_idx = '0;
        idx      = '0;
        for (int i = 0; i < Depth; i++) begin
            idx = rd_ptr_q + PtrW'(i);
            if (CntW'(i) < count_q && !(i == 0 && pop) &&
                addr_mem[idx] == wb_waddr_i) begin
                coal_hit = 1'b1;
                coal_idx = idx;
            end
        end
    end
    assign wb_ready_o = !full || coal_hit;
`else
    assign coal_hit   = 1'b0;
    assign coal_idx   = '0;
    assign wb_ready_o = !full;
`endif

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Control and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rf_we_q <= pop;
            drop_q  <= accept && illegal;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + PtrW'(1);
                rf_waddr_q <= addr_mem[rd_ptr_q];
                rf_wdata_q <= data_mem[rd_ptr_q];
            end
        end
    end

    // FIFO storage; only entries inside [rd_ptr, rd_ptr+count) are ever read
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= wb_waddr_i;
            data_mem[wr_ptr_q] <= wb_wdata_i;
        end else if (accept && !illegal && coal_hit) begin
            data_mem[coal_idx] <= wb_wdata_i;
        end
    end

    // Candidates are scanned from oldest (the in-flight ISSUE write) to
    // youngest (the FIFO tail). A later match overrides an earlier one.
    function automatic fwd_t fwd_lookup(input logic [4:0] raddr);
        fwd_t            r;
        logic [PtrW-1:0] idx;
        r.hit  = 1'b0;
        r.data = '0;
        idx    = '0;
        if (raddr != 5'd0) begin
            if (state_q == ISSUE && rf_waddr_q == raddr) begin
                r.hit  = 1'b1;
                r.data = rf_wdata_q;
            end
            for (int i = 0; i < Depth; i++) begin
                idx = rd_ptr_q + PtrW'(i);
                if (CntW'(i) < count_q && addr_mem[idx] == raddr) begin
                    r.hit  = 1'b1;
                    r.data = data_mem[idx];
                end
            end
        end
        return r;
    endfunction

    always_comb fwd_a = fwd_lookup(raddr_a_i);
    always_comb fwd_b = fwd_lookup(raddr_b_i);

    assign fwd_hit_a_o  = fwd_a.hit;
    assign fwd_data_a_o = fwd_a.data;
    assign fwd_hit_b_o  = fwd_b.hit;
    assign fwd_data_b_o = fwd_b.data;

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);
    assign full_o     = full;
    assign drop_o     = drop_q;

endmodule
